uart_transmitter: RTL and testbench



---
 rtl/uart_transmitter_if.sv | 24 ++
 rtl/uart_transmitter.sv | 165 ++++++++++++++++
 tb/tb_uart_transmitter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmitter_if.sv
// Transmit-side handshake bundle between a UART user and the uart_transmitter block.
// The master drives requests and sees the line and busy; the slave is the transmitter.
interface uart_transmitter_if #(
  parameter int unsigned PAYLOAD_BITS = 8
);
  logic                    uart_txd;
  logic                    uart_tx_en;
  logic [PAYLOAD_BITS-1:0] uart_tx_data;
  logic                    uart_tx_busy;

  modport master (
    output uart_tx_en,
    output uart_tx_data,
    input  uart_txd,
    input  uart_tx_busy
  );

  modport slave (
    input  uart_tx_en,
    input  uart_tx_data,
    output uart_txd,
    output uart_tx_busy
  );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, PAYLOAD_BITS data bits LSB first, STOP_BITS stop bits, no parity.
// The line is driven from a flop so it is glitch-free; busy is high whenever a frame is in flight.
module uart_transmitter #(
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input logic               clk,
  input logic               resetn,
  uart_transmitter_if.slave tx_if
);

  localparam int unsigned CyclesPerBit = CLK_HZ / BIT_RATE;
  localparam int unsigned CntW         = $clog2(CyclesPerBit + 1);
  localparam int unsigned BitCntW      = $clog2(PAYLOAD_BITS + STOP_BITS + 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cycle_cnt_q, cycle_cnt_d;
  logic [BitCntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [PAYLOAD_BITS-1:0] shreg_q, shreg_d;
  logic [PAYLOAD_BITS-1:0] shreg_shifted;
  logic                    txd_q, txd_d;
  logic                    busy;

  logic                    tx_en;
  logic [PAYLOAD_BITS-1:0] tx_data;
  logic                    bit_end;
  logic                    last_data;
  logic                    last_stop;
  logic                    frame_end;
  logic                    load;

  assign tx_en         = tx_if.uart_tx_en;
  assign tx_data       = tx_if.uart_tx_data;
  assign shreg_shifted = shreg_q >> 1;

  assign bit_end   = (cycle_cnt_q == CntW'(CyclesPerBit - 1));
  assign last_data = (bit_cnt_q == BitCntW'(PAYLOAD_BITS - 1));
  assign last_stop = (bit_cnt_q == BitCntW'(STOP_BITS - 1));
  assign frame_end = (state_q == StStop) && bit_end && last_stop;

  // A request seen on the final stop-bit cycle is taken directly, so back-to-back
  // frames leave no idle cycle between the last stop bit and the next start bit.
  assign load = tx_en && ((state_q == StIdle) || frame_end);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (tx_en) state_d = StStart;
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end && last_data) state_d = StStop;
      end
      StStop: begin
        if (frame_end) state_d = tx_en ? StStart : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    busy = (state_q != StIdle);
  end

  // Datapath next-state: bit timing, bit counting, shifting and the registered line value.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    txd_d       = txd_q;
    if (load) begin
      cycle_cnt_d = '0;
      bit_cnt_d   = '0;
      shreg_d     = tx_data;
      txd_d       = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cycle_cnt_d = '0;
          bit_cnt_d   = '0;
          txd_d       = 1'b1;
        end
        StStart: begin
          if (bit_end) begin
            cycle_cnt_d = '0;
            txd_d       = shreg_q[0];
          end else begin
            cycle_cnt_d = cycle_cnt_q + CntW'(1);
            txd_d       = 1'b0;
          end
        end
        StData: begin
          if (bit_end) begin
            cycle_cnt_d = '0;
            if (last_data) begin
              bit_cnt_d = '0;
              txd_d     = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + BitCntW'(1);
              shreg_d   = shreg_shifted;
              txd_d     = shreg_shifted[0];
            end
          end else begin
            cycle_cnt_d = cycle_cnt_q + CntW'(1);
          end
        end
        StStop: begin
          txd_d = 1'b1;
          if (bit_end) begin
            cycle_cnt_d = '0;
            bit_cnt_d   = last_stop ? '0 : bit_cnt_q + BitCntW'(1);
          end else begin
            cycle_cnt_d = cycle_cnt_q + CntW'(1);
          end
        end
        default: begin
          cycle_cnt_d = '0;
          bit_cnt_d   = '0;
          txd_d       = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cycle_cnt_q <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      txd_q       <= 1'b1;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      txd_q       <= txd_d;
    end
  end

  assign tx_if.uart_txd     = txd_q;
  assign tx_if.uart_tx_busy = busy;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter at 10 clocks per bit, with a per-cycle line
// model and an independent bit-centre receiver model.
module tb_uart_transmitter;

  localparam int unsigned ClkHz   = 1_000_000;
  localparam int unsigned BitRate = 100_000;
  localparam int unsigned Cpb     = ClkHz / BitRate;
  localparam int unsigned Frame   = 10 * Cpb;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  uart_transmitter_if #(.PAYLOAD_BITS(8)) tx_if ();

  uart_transmitter #(
    .BIT_RATE    (BitRate),
    .CLK_HZ      (ClkHz),
    .PAYLOAD_BITS(8),
    .STOP_BITS   (1)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .tx_if (tx_if)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic        cap [0:511];

  // Line level t cycles after the accepting edge: start, 8 data bits LSB first, then high.
  function automatic logic line_model(input logic [7:0] b, input int unsigned t);
    int unsigned idx;
    idx = t / Cpb;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  // Receiver: find the start edge in cap[], then sample each data bit at its centre.
  function automatic logic [7:0] rx_decode(input int unsigned from, input int unsigned len);
    int          s;
    logic [7:0]  d;
    s = -1;
    d = 8'h00;
    for (int unsigned i = from; i < from + len; i++) begin
      if (s < 0 && cap[i] === 1'b0) s = int'(i);
    end
    if (s < 0) return 8'hxx;
    for (int k = 0; k < 8; k++) d[k] = cap[s + (k + 1) * int'(Cpb) + int'(Cpb) / 2];
    if (cap[s + 9 * int'(Cpb) + int'(Cpb) / 2] !== 1'b1) return 8'hxx;
    return d;
  endfunction

  // Called on a negedge with the DUT idle; returns on the negedge after the accepting edge.
  task automatic send_start(input logic [7:0] b);
    tx_if.uart_tx_en   = 1'b1;
    tx_if.uart_tx_data = b;
    @(negedge clk);
    tx_if.uart_tx_en   = 1'b0;
    tx_if.uart_tx_data = 8'($urandom);
  endtask

  task automatic test_reset();
    tx_if.uart_tx_en   = 1'b0;
    tx_if.uart_tx_data = 8'h00;
    resetn             = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tx_if.uart_txd !== 1'b1 || tx_if.uart_tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got txd=%b busy=%b, want txd=1 busy=0",
               tx_if.uart_txd, tx_if.uart_tx_busy);
    end
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tx_if.uart_tx_data = 8'($urandom);
      @(negedge clk);
      checks++;
      if (tx_if.uart_txd !== 1'b1 || tx_if.uart_tx_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got txd=%b busy=%b, want txd=1 busy=0",
                 i, tx_if.uart_txd, tx_if.uart_tx_busy);
      end
    end
  endtask

  task automatic test_single_byte(input logic [7:0] b);
    int unsigned busy_cycles;
    logic        exp_busy;
    logic [9:0]  centres;
    logic [9:0]  exp_centres;
    logic [7:0]  got;
    busy_cycles = 0;
    send_start(b);
    for (int unsigned t = 0; t < Frame + 5; t++) begin
      cap[t]   = tx_if.uart_txd;
      exp_busy = (t < Frame);
      checks++;
      if (tx_if.uart_txd !== line_model(b, t) || tx_if.uart_tx_busy !== exp_busy) begin
        errors++;
        $display("FAIL frame_%02h t=%0d: got txd=%b busy=%b, want txd=%b busy=%b",
                 b, t, tx_if.uart_txd, tx_if.uart_tx_busy, line_model(b, t), exp_busy);
      end
      if (tx_if.uart_tx_busy === 1'b1) busy_cycles++;
      @(negedge clk);
    end
    checks++;
    if (busy_cycles != Frame) begin
      errors++;
      $display("FAIL busy_len_%02h: got %0d cycles, want %0d", b, busy_cycles, Frame);
    end
    for (int k = 0; k < 10; k++) centres[k] = cap[k * int'(Cpb) + int'(Cpb) / 2];
    exp_centres = {1'b1, b, 1'b0};
    checks++;
    if (centres !== exp_centres) begin
      errors++;
      $display("FAIL centres_%02h: got %b, want %b (bit0 = start)", b, centres, exp_centres);
    end
    got = rx_decode(0, Frame);
    checks++;
    if (got !== b) begin
      errors++;
      $display("FAIL rx_decode: got %02h, want %02h", got, b);
    end
  endtask

  task automatic test_random_bytes();
    for (int i = 0; i < 6; i++) test_single_byte(8'($urandom));
  endtask

  task automatic test_busy_ignore();
    logic       exp_busy;
    logic [7:0] got;
    send_start(8'h41);
    for (int unsigned t = 0; t < Frame + 30; t++) begin
      cap[t]   = tx_if.uart_txd;
      exp_busy = (t < Frame);
      checks++;
      if (tx_if.uart_txd !== line_model(8'h41, t) || tx_if.uart_tx_busy !== exp_busy) begin
        errors++;
        $display("FAIL busy_ignore t=%0d: got txd=%b busy=%b, want txd=%b busy=%b",
                 t, tx_if.uart_txd, tx_if.uart_tx_busy, line_model(8'h41, t), exp_busy);
      end
      if (t == 30) begin
        tx_if.uart_tx_en   = 1'b1;
        tx_if.uart_tx_data = 8'hFF;
      end else if (t == 31) begin
        tx_if.uart_tx_en = 1'b0;
      end
      @(negedge clk);
    end
    got = rx_decode(0, Frame);
    checks++;
    if (got !== 8'h41) begin
      errors++;
      $display("FAIL busy_ignore_decode: got %02h, want 41", got);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  bytes [3];
    int unsigned f;
    int unsigned off;
    logic        exp_txd;
    logic        exp_busy;
    bytes[0] = 8'h00;
    bytes[1] = 8'h00;
    bytes[2] = 8'($urandom);
    tx_if.uart_tx_en   = 1'b1;
    tx_if.uart_tx_data = bytes[0];
    @(negedge clk);
    for (int unsigned t = 0; t < 3 * Frame + 10; t++) begin
      f        = t / Frame;
      off      = t % Frame;
      exp_txd  = (f < 3) ? line_model(bytes[f], off) : 1'b1;
      exp_busy = (f < 3);
      checks++;
      if (tx_if.uart_txd !== exp_txd || tx_if.uart_tx_busy !== exp_busy) begin
        errors++;
        $display("FAIL back_to_back frame %0d off=%0d: got txd=%b busy=%b, want txd=%b busy=%b",
                 f, off, tx_if.uart_txd, tx_if.uart_tx_busy, exp_txd, exp_busy);
      end
      // Mid-frame data/enable changes must only matter at the next frame boundary.
      if (off == 50 && f < 2) tx_if.uart_tx_data = bytes[f+1];
      if (off == 50 && f == 2) tx_if.uart_tx_en = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'($urandom) | 8'h08;
    send_start(b);
    repeat (4 * Cpb + Cpb / 2) @(negedge clk);
    checks++;
    if (tx_if.uart_txd !== b[3] || tx_if.uart_tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_bit3: got txd=%b busy=%b, want txd=%b busy=1",
               tx_if.uart_txd, tx_if.uart_tx_busy, b[3]);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (tx_if.uart_txd !== 1'b1 || tx_if.uart_tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_immediate: got txd=%b busy=%b, want txd=1 busy=0",
               tx_if.uart_txd, tx_if.uart_tx_busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (tx_if.uart_txd !== 1'b1 || tx_if.uart_tx_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got txd=%b busy=%b, want txd=1 busy=0",
                 i, tx_if.uart_txd, tx_if.uart_tx_busy);
      end
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    test_single_byte(8'h7E);
  endtask

  initial begin
    test_reset();
    test_single_byte(8'h55);
    test_single_byte(8'hA3);
    test_random_bytes();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
